// File: rtl/or_stim_pkg.sv
// Shared types and helpers for the OR-gate stimulus sequencer.
// Optional build macro OR_STIM_GRAY_EN selects Gray-coded `a` sequencing.
package or_stim_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP0,
    SWEEP1,
    FIN
  } state_t;

  function automatic logic [31:0] bin2gray(input logic [31:0] idx);
    return idx ^ (idx >> 1);
  endfunction

endpackage

// File: rtl/or_stim_if.sv
// Stimulus/handshake bundle between the sequencer (master) and the gate-side checker (slave).
// PW must equal $clog2(PASSES+1) of the attached or_stim_gen.
interface or_stim_if
  import or_stim_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned PW    = 1
);

  logic             start;
  logic             step_ready;
  logic [WIDTH-1:0] a;
  logic             en;
  logic             valid;
  logic             busy;
  logic             done;
  logic [PW-1:0]    pass_idx;

  modport master (
    input  start, step_ready,
    output a, en, valid, busy, done, pass_idx
  );

  modport slave (
    output start, step_ready,
    input  a, en, valid, busy, done, pass_idx
  );

endinterface

// File: rtl/or_stim_dwell_timer.sv
// Per-vector dwell counter: expires at DWELL-1 when ready, saturates there while ready is low.
module or_stim_dwell_timer
  import or_stim_pkg::*;
#(
  parameter int unsigned DWELL = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic ready,
  output logic expire
);

  localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] cnt;

  assign expire = (cnt == LAST) && ready;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (cnt != LAST) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/or_stim_gen.sv
// Synthesizable, restartable sweep of every (a, en) combination for the enabled OR gate.
// Build macro OR_STIM_GRAY_EN: `a` follows the reflected Gray code of the internal index.
module or_stim_gen
  import or_stim_pkg::*;
#(
  parameter int unsigned WIDTH  = DEFAULT_WIDTH,
  parameter int unsigned DWELL  = 10,
  parameter int unsigned PASSES = 1
) (
  input logic       clk,
  input logic       rst,
  or_stim_if.master bus
);

  localparam int unsigned PW = $clog2(PASSES + 1);
  localparam logic [WIDTH-1:0] IDX_LAST = '1;

  state_t           state, state_n;
  logic [WIDTH-1:0] idx, idx_n;
  logic [PW-1:0]    pass, pass_n;
  logic             expire;
  logic             in_sweep;
  logic             sweep_n;
  logic [WIDTH-1:0] a_n;

  logic [WIDTH-1:0] a_q;
  logic             en_q, valid_q, busy_q, done_q;

  assign in_sweep = (state == SWEEP0) || (state == SWEEP1);
  assign sweep_n  = (state_n == SWEEP0) || (state_n == SWEEP1);

  // Clearing outside the sweeps guarantees the count starts at 0 on SWEEP0 entry.
  or_stim_dwell_timer #(
    .DWELL(DWELL)
  ) u_dwell (
    .clk   (clk),
    .rst   (rst),
    .clear (!in_sweep || expire),
    .ready (bus.step_ready),
    .expire(expire)
  );

  always_comb begin
    state_n = state;
    idx_n   = idx;
    pass_n  = pass;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_n = SWEEP0;
          idx_n   = '0;
          pass_n  = '0;
        end
      end
      SWEEP0: begin
        if (expire) begin
          if (idx == IDX_LAST) begin
            state_n = SWEEP1;
            idx_n   = '0;
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
      SWEEP1: begin
        if (expire) begin
          if (idx != IDX_LAST) begin
            idx_n = idx + 1'b1;
          end else begin
            idx_n = '0;
            if ((32'(pass) + 32'd1) < PASSES) begin
              pass_n  = pass + 1'b1;
              state_n = SWEEP0;
            end else begin
              state_n = FIN;
            end
          end
        end
      end
      FIN: begin
        state_n = IDLE;
        pass_n  = '0;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    a_n = '0;
    if (sweep_n) begin
`ifdef OR_STIM_GRAY_EN
      a_n = WIDTH'(bin2gray(32'(idx_n)));
`else
      a_n = idx_n;
`endif
    end
  end

  // Outputs are registered from next-state values so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      pass    <= '0;
      a_q     <= '0;
      en_q    <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      pass    <= pass_n;
      a_q     <= a_n;
      en_q    <= (state_n == SWEEP1);
      valid_q <= sweep_n;
      busy_q  <= (state_n != IDLE);
      done_q  <= (state_n == FIN);
    end
  end

  assign bus.a        = a_q;
  assign bus.en       = en_q;
  assign bus.valid    = valid_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.pass_idx = pass;

endmodule

// File: tb/tb_or_stim_gen.sv
// Bench for or_stim_gen: reset/idle vector table plus model-checked runs (full, stall, random, reset, multi-pass).
module tb_or_stim_gen;
  import or_stim_pkg::*;

  typedef struct packed {
    logic [3:0] a;
    logic       en;
    logic       valid;
    logic       busy;
    logic       done;
    logic [1:0] pass;
  } out_t;

  typedef struct packed {
    logic [3:0] a;
    logic       en;
    logic [1:0] pass;
  } vec_t;

  typedef struct {
    logic rst;
    logic start;
    out_t exp;
  } row_t;

  localparam int M_FULL   = 0;
  localparam int M_STALL  = 1;
  localparam int M_RAND   = 2;
  localparam int M_RESET  = 3;
  localparam int M_STARTS = 4;

`ifdef OR_STIM_GRAY_EN
  localparam logic [3:0] SEQ [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                      4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
`else
  localparam logic [3:0] SEQ [16] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
                                      4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
`endif

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  logic [3:0] obs[$];

  or_stim_if #(.WIDTH(4), .PW(1)) ifa ();
  or_stim_if #(.WIDTH(4), .PW(2)) ifb ();

  or_stim_gen #(.WIDTH(4), .DWELL(2), .PASSES(1)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa)
  );

  or_stim_gen #(.WIDTH(4), .DWELL(1), .PASSES(2)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic out_t mk(input logic [3:0] a, input logic en, input logic valid,
                              input logic busy, input logic done, input logic [1:0] pass);
    out_t o;
    o.a = a; o.en = en; o.valid = valid; o.busy = busy; o.done = done; o.pass = pass;
    return o;
  endfunction

  function automatic out_t sample(input int which);
    out_t o;
    if (which == 0) begin
      o = mk(ifa.a, ifa.en, ifa.valid, ifa.busy, ifa.done, {1'b0, ifa.pass_idx});
    end else begin
      o = mk(ifb.a, ifb.en, ifb.valid, ifb.busy, ifb.done, ifb.pass_idx);
    end
    return o;
  endfunction

  function automatic logic [3:0] map_a(input int i);
`ifdef OR_STIM_GRAY_EN
    return 4'(i ^ (i >> 1));
`else
    return 4'(i);
`endif
  endfunction

  task automatic chk(input string name, input out_t got, input out_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got a=%h en=%b valid=%b busy=%b done=%b pass=%0d, want a=%h en=%b valid=%b busy=%b done=%b pass=%0d",
               name, got.a, got.en, got.valid, got.busy, got.done, got.pass,
               exp.a, exp.en, exp.valid, exp.busy, exp.done, exp.pass);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, got, exp);
    end
  endtask

  task automatic drive(input int which, input logic s, input logic r);
    if (which == 0) begin
      ifa.start = s; ifa.step_ready = r;
    end else begin
      ifb.start = s; ifb.step_ready = r;
    end
  endtask

  // Reference: the run is a list of (a, en, pass) vectors; each is shown for at least
  // `dwell` cycles and leaves on the first edge after that with step_ready high.
  task automatic run_seq(input int which, input int dwell, input int passes, input int mode,
                         output int cycles, output int dones, output int done_at, output int hold5);
    vec_t q[$];
    vec_t v;
    out_t got;
    int   h;
    bit   finished;
    bit   have_prev;
    logic [3:0] prev_a;
    logic r, s;
    string tag;
    tag = (which == 0) ? "seq_a" : "seq_b";
    for (int p = 0; p < passes; p++)
      for (int e = 0; e < 2; e++)
        for (int i = 0; i < 16; i++) begin
          v.a = map_a(i); v.en = (e == 1); v.pass = 2'(p);
          q.push_back(v);
        end
    cycles = 0; dones = 0; done_at = 0; hold5 = 0;
    finished = 0; have_prev = 0; prev_a = '0;
    drive(which, 1'b1, 1'b1);
    tick();
    drive(which, 1'b0, 1'b1);
    h = 1;
    for (int t = 0; t < 2000 && !finished; t++) begin
      got = sample(which);
      cycles++;
      if (q.size() > 0) chk(tag, got, mk(q[0].a, q[0].en, 1'b1, 1'b1, 1'b0, q[0].pass));
      else              chk(tag, got, mk(4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 2'(passes - 1)));
      if (got.done === 1'b1) begin
        dones++;
        done_at = cycles;
      end
      if (q.size() > 0 && h == 1) begin
        obs.push_back(got.a);
`ifdef OR_STIM_GRAY_EN
        if (have_prev) chk_int("gray_one_bit", $countones(got.a ^ prev_a), 1);
`endif
        have_prev = 1;
        prev_a = got.a;
      end
      if (q.size() > 0 && q[0].a == 4'h5 && !q[0].en && q[0].pass == 2'd0) hold5++;

      if (mode == M_RESET && q.size() > 0 && q[0].en && q[0].a == 4'h9) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("reset_mid", sample(which), '0);
        tick();
        chk("reset_after", sample(which), '0);
        finished = 1;
      end else if (q.size() == 0) begin
        drive(which, (mode == M_STARTS), 1'b1);
        tick();
        drive(which, 1'b0, 1'b1);
        chk("fin_to_idle", sample(which), '0);
        tick();
        chk("idle_hold", sample(which), '0);
        finished = 1;
      end else begin
        r = 1'b1;
        s = 1'b0;
        case (mode)
          M_STALL:  if (q[0].a == 4'h5 && !q[0].en && h >= 2 && h <= 5) r = 1'b0;
          M_RAND:   r = ($urandom_range(0, 2) != 0);
          M_STARTS: s = ($urandom_range(0, 3) == 0);
          default:  r = 1'b1;
        endcase
        drive(which, s, r);
        tick();
        if (h >= dwell && r) begin
          void'(q.pop_front());
          h = 1;
        end else begin
          h++;
        end
      end
    end
    drive(which, 1'b0, 1'b1);
    if (!finished) begin
      total++;
      bad++;
      $display("FAIL run_timeout: mode=%0d got no end after %0d cycles, want end", mode, cycles);
    end
  endtask

  initial begin
    row_t rows[12];
    int cycles, dones, done_at, hold5;

    rst = 1'b1;
    ifa.start = 1'b0; ifa.step_ready = 1'b1;
    ifb.start = 1'b0; ifb.step_ready = 1'b1;

    rows[0]  = '{1'b1, 1'b0, out_t'('0)};
    rows[1]  = '{1'b1, 1'b1, out_t'('0)};
    for (int i = 2; i < 7; i++) rows[i] = '{1'b0, 1'b0, out_t'('0)};
    rows[7]  = '{1'b0, 1'b1, mk(4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0)};
    rows[8]  = '{1'b0, 1'b0, mk(4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0)};
    rows[9]  = '{1'b0, 1'b0, mk(4'h1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0)};
    rows[10] = '{1'b1, 1'b0, out_t'('0)};
    rows[11] = '{1'b0, 1'b0, out_t'('0)};

    for (int i = 0; i < 12; i++) begin
      rst = rows[i].rst;
      ifa.start = rows[i].start;
      tick();
      chk($sformatf("table_%0d", i), sample(0), rows[i].exp);
    end
    rst = 1'b0;
    ifa.start = 1'b0;

    run_seq(0, 2, 1, M_FULL, cycles, dones, done_at, hold5);
    chk_int("full_cycles", cycles, 65);
    chk_int("full_dones", dones, 1);
    chk_int("full_done_at", done_at, 65);
    chk_int("full_hold5", hold5, 2);

    run_seq(0, 2, 1, M_STALL, cycles, dones, done_at, hold5);
    chk_int("stall_cycles", cycles, 69);
    chk_int("stall_hold5", hold5, 6);
    chk_int("stall_dones", dones, 1);

    for (int k = 0; k < 2; k++) begin
      run_seq(0, 2, 1, M_RAND, cycles, dones, done_at, hold5);
      chk_int("rand_dones", dones, 1);
      chk_int("rand_done_last", done_at, cycles);
    end

    run_seq(0, 2, 1, M_RESET, cycles, dones, done_at, hold5);
    chk_int("reset_no_done", dones, 0);
    run_seq(0, 2, 1, M_FULL, cycles, dones, done_at, hold5);
    chk_int("post_reset_cycles", cycles, 65);

    obs.delete();
    run_seq(1, 1, 2, M_STARTS, cycles, dones, done_at, hold5);
    chk_int("multi_cycles", cycles, 65);
    chk_int("multi_dones", dones, 1);
    chk_int("multi_vectors", obs.size(), 64);
    for (int i = 0; i < 16 && i < obs.size(); i++)
      chk_int($sformatf("seq_order_%0d", i), int'(obs[i]), int'(SEQ[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/or_stim_gen.md
Name: or_stim_gen

Overview:
Upstream stimulus sequencer for the enabled 4-bit OR gate stage. It drives the gate's `a` vector and `en` input. It sweeps every input combination: first all `a` values with `en`=0, then all with `en`=1. Each vector is held for a programmable dwell time. A downstream checker can stall advancement with a ready handshake. This replaces free-running initial-block stimulus with a synthesizable, restartable source.

Parameters:
- WIDTH, 4, width of the `a` vector driven to the gate.
- DWELL, 10, clock cycles each vector is held (minimum 1).
- PASSES, 1, number of complete en=0/en=1 sweeps per start (minimum 1).

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  begin a run; sampled only in IDLE.
- step_ready  input  1  downstream consumer permits advance to the next vector.
- a  output  WIDTH  stimulus vector to the gate.
- en  output  1  stimulus enable to the gate.
- valid  output  1  `a`/`en` hold a vector of the current run.
- busy  output  1  run in progress (state is not IDLE).
- done  output  1  one-cycle pulse when a run completes.
- pass_idx  output  $clog2(PASSES+1)  index of the current pass, 0-based.

Behaviour:
- Reset, synchronous, takes effect on the rising edge with rst=1:
  - state returns to IDLE.
  - a=0, en=0, valid=0, busy=0, done=0, pass_idx=0.
  - dwell counter returns to 0.
  - Reset mid-run aborts the run immediately; done is not pulsed.
- States: IDLE, SWEEP0 (en=0), SWEEP1 (en=1), FIN.
- IDLE:
  - Outputs a=0, en=0, valid=0.
  - When start=1, the next cycle enters SWEEP0 with a=0, valid=1, dwell counter=0.
- SWEEP0 / SWEEP1:
  - The dwell counter increments each cycle.
  - The vector advances only when the dwell counter equals DWELL-1 and step_ready=1.
  - If step_ready=0 at that point, the counter saturates at DWELL-1 and the vector holds until step_ready=1 (stall).
  - On advance, the dwell counter is cleared and `a` moves to its successor.
- Last vector of a sweep (a = 2^WIDTH-1 in binary order):
  - Advancing from SWEEP0 enters SWEEP1 with a=0, en=1.
  - Advancing from SWEEP1 with pass_idx<PASSES-1 increments pass_idx and re-enters SWEEP0 with a=0, en=0.
  - Otherwise the block enters FIN.
- FIN:
  - Lasts one cycle: done=1, valid=0, a=0, en=0.
  - Then returns to IDLE with pass_idx=0.
- start is ignored while busy.
- start asserted in the FIN cycle is ignored; it must be re-asserted in IDLE.
- Cycle counts:
  - Latency from start to first valid vector: 1 cycle.
  - Total run length with no stalls: PASSES·2·2^WIDTH·DWELL cycles of valid, plus 1 FIN cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

Optional Feature:
- Macro: OR_STIM_GRAY_EN.
- When defined:
  - `a` steps through the reflected Gray sequence, a = idx ^ (idx>>1), using an internal binary index idx.
  - The sweep ends when idx = 2^WIDTH-1, i.e. a = 2^(WIDTH-1).
  - Only one bit of `a` toggles per advance, including the SWEEP0→SWEEP1 boundary, where a returns to 0.
- When undefined: plain binary count. Port list and timing are identical in both builds.

Decomposition:
- Package or_stim_pkg holds:
  - the state enum type (IDLE, SWEEP0, SWEEP1, FIN);
  - a function bin2gray(idx);
  - the localparam for the default WIDTH.
- One natural sub-module, or_stim_dwell_timer:
  - Inputs: clk, rst, clear, ready.
  - Output: expire, asserted at count DWELL-1 with ready=1.
  - Parameter: DWELL.
  - The counter saturates while ready is low.

Test Plan:
- Reset and idle: hold rst for 2 cycles, then release with start=0 for 5 cycles → a=0, en=0, valid=0, busy=0, done=0 throughout.
- Full sweep (DWELL=2, PASSES=1, step_ready=1): pulse start →
  - valid rises 1 cycle later;
  - `a` goes 0,0,1,1,…,F,F with en=0, then the same with en=1;
  - done pulses exactly at cycle 65 after valid rises, then busy=0.
- Stall: in the DWELL=2 run, drop step_ready for 4 cycles while a=5 → a=5 is held 6 cycles total, then advances to 6; total run is 4 cycles longer.
- Multi-pass and ignored start (PASSES=2): pulse start again mid-run → no restart; pass_idx goes 0→1 at the second SWEEP0 entry; done pulses once at the end.
- Mid-run reset: assert rst while SWEEP1, a=9 → next cycle a=0, en=0, valid=0, busy=0, no done; a new start runs a full sweep from a=0, en=0.
- Gray build (OR_STIM_GRAY_EN, DWELL=1): a sequence is 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8, and consecutive values differ by exactly one bit.
